// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Types and constants shared by the hazard control unit and its forwarding
// sub-module.
//   hcu_state_t  : control FSM states (RUN, STALL, FLUSH)
//   FWD_*        : operand forward select codes
//   STALL_CNT_W  : width of the internal load-latency counter. LOAD_LAT is
//                  at most 7, so LOAD_LAT-1 fits in 3 bits.
// Optional feature macro used by the clients: HAZARD_FORWARD_EN
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hcu_state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_EX   = 2'b01;  // operand from the EX-stage result
  localparam logic [1:0] FWD_MEM  = 2'b10;  // operand from the MEM-stage result

  localparam int unsigned STALL_CNT_W = 3;

endpackage : hazard_pkg

// File: rtl/hazard_control_unit_forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
// Purely combinational operand-forwarding selector for the instruction in ID.
// Only instantiated when HAZARD_FORWARD_EN is defined.
// Ports:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source registers and read flags
//   ex_rd, ex_memread, ex_regwrite       : EX-stage destination info
//   mem_rd, mem_regwrite                 : MEM-stage destination info
//   fwd_a, fwd_b                         : forward select (FWD_NONE/EX/MEM)
// -----------------------------------------------------------------------------
module forward_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // A load in EX has no result yet, so it is never a forwarding source; the
  // load-use stall covers that case. The younger (EX) producer wins over MEM.
  function automatic logic [1:0] pick(input logic              use_src,
                                      input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (use_src && ex_regwrite && !ex_memread &&
        (rs == ex_rd) && (ex_rd != '0)) begin
      sel = FWD_EX;
    end else if (use_src && mem_regwrite &&
                 (rs == mem_rd) && (mem_rd != '0)) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = pick(id_use_rs1, id_rs1);
    fwd_b = pick(id_use_rs2, id_rs2);
  end

endmodule : forward_select

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline hazard detection and control for a classic 5-stage pipeline.
// Detects load-use hazards (stalling LOAD_LAT cycles), squashes the fetched
// instruction on a taken branch/jump, and counts stalled cycles.
//
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   : forward_select is instantiated and fwd_a/fwd_b are ports;
//               ALU-result dependencies are resolved by forwarding.
//   undefined : no forwarding ports; any regwrite dependency on EX or MEM
//               causes a one-cycle stall.
//
// Ports:
//   clock, reset (async, active-high)
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID-stage sources
//   ex_rd, ex_memread, ex_regwrite       : EX-stage destination info
//   mem_rd, mem_regwrite                 : MEM-stage destination info
//   ex_branch_taken                      : taken branch/jump resolved in EX
//   pc_write, if_id_write                : PC / IF-ID write enables
//   id_ex_bubble, if_id_flush            : NOP into ID/EX, clear IF/ID
//   stall_count                          : saturating stalled-cycle count
//   fwd_a, fwd_b                         : forward selects (feature only)
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [CNT_W-1:0]  stall_count
`ifdef HAZARD_FORWARD_EN
  ,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`endif
);

  localparam logic [STALL_CNT_W-1:0] LAT_RELOAD = STALL_CNT_W'(LOAD_LAT - 1);

  hcu_state_t             state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]       stall_count_q, stall_count_d;

  logic load_use;
  logic raw_hazard;

  // A source depends on a stage when it is actually read, names the stage's
  // destination, and that destination is not the hard-wired zero register.
  function automatic logic src_match(input logic              use_src,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rd);
    return use_src && (rs == rd) && (rd != '0);
  endfunction

  assign load_use = ex_memread &&
                    (src_match(id_use_rs1, id_rs1, ex_rd) ||
                     src_match(id_use_rs2, id_rs2, ex_rd));

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_sel, fwd_b_sel;

  forward_select #(
    .REG_AW (REG_AW)
  ) u_forward_select (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_regwrite  (ex_regwrite),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .fwd_a        (fwd_a_sel),
    .fwd_b        (fwd_b_sel)
  );

  // Selects read as "no forward" while reset is held.
  assign fwd_a = reset ? FWD_NONE : fwd_a_sel;
  assign fwd_b = reset ? FWD_NONE : fwd_b_sel;

  // Forwarding resolves every non-load dependency.
  assign raw_hazard = 1'b0;
`else
  // Without forwarding, any pending write to a source must drain first.
  assign raw_hazard =
      (ex_regwrite  && (src_match(id_use_rs1, id_rs1, ex_rd) ||
                        src_match(id_use_rs2, id_rs2, ex_rd))) ||
      (mem_regwrite && (src_match(id_use_rs1, id_rs1, mem_rd) ||
                        src_match(id_use_rs2, id_rs2, mem_rd)));
`endif

  // Next-state and control outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          // Branch wins over any hazard on the (wrong-path) ID instruction.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = FLUSH;
        end else if (load_use || raw_hazard) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          // This cycle is the first stall cycle; STALL covers the rest.
          if (load_use && (LOAD_LAT > 1)) begin
            state_d = STALL;
            cnt_d   = LAT_RELOAD;
          end
        end
      end

      STALL: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = FLUSH;
          cnt_d        = '0;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q <= STALL_CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      FLUSH: begin
        // The ID instruction is on the squashed path, so its hazards are
        // irrelevant; keep it out of the pipe for one more cycle.
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating stalled-cycle counter.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed test of hazard_control_unit. Two instances share one stimulus:
//   dut   : LOAD_LAT=2, CNT_W=16
//   dut_1 : LOAD_LAT=1, CNT_W=4 (single-cycle load stall, counter saturation)
// Forwarding checks are compiled in when HAZARD_FORWARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_memread, ex_regwrite, mem_regwrite, ex_branch_taken;

  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [15:0] stall_count;
  logic        pc_write_1, if_id_write_1, id_ex_bubble_1, if_id_flush_1;
  logic [3:0]  stall_count_1;
`ifdef HAZARD_FORWARD_EN
  logic [1:0]  fwd_a, fwd_b, fwd_a_1, fwd_b_1;
`endif

  int checks   = 0;
  int failures = 0;

  hazard_control_unit #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_regwrite     (ex_regwrite),
    .mem_rd          (mem_rd),
    .mem_regwrite    (mem_regwrite),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .stall_count     (stall_count)
`ifdef HAZARD_FORWARD_EN
    ,
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
`endif
  );

  hazard_control_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) dut_1 (
    .clock           (clock),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_regwrite     (ex_regwrite),
    .mem_rd          (mem_rd),
    .mem_regwrite    (mem_regwrite),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write_1),
    .if_id_write     (if_id_write_1),
    .id_ex_bubble    (id_ex_bubble_1),
    .if_id_flush     (if_id_flush_1),
    .stall_count     (stall_count_1)
`ifdef HAZARD_FORWARD_EN
    ,
    .fwd_a           (fwd_a_1),
    .fwd_b           (fwd_b_1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pc_write, if_id_write, id_ex_bubble, if_id_flush of the LOAD_LAT=2 instance
  task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                         input logic bub, input logic fl);
    chk({tag, ".pc_write"},     pc_write,     pcw);
    chk({tag, ".if_id_write"},  if_id_write,  ifw);
    chk({tag, ".id_ex_bubble"}, id_ex_bubble, bub);
    chk({tag, ".if_id_flush"},  if_id_flush,  fl);
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; mem_regwrite = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic load_use_r5();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic cyc(input string step);
    @(posedge clock);
    #1;
    $display("[tb] t=%0t step %s", $time, step);
  endtask

  initial begin
    reset = 1'b1;
    clr();
    #1;
    chk_ctl("reset", 1, 1, 0, 0);
    chk("reset.stall_count", stall_count, 0);
    chk("reset.stall_count_1", stall_count_1, 0);
    @(negedge clock);
    reset = 1'b0;

    // Load into x0 is never a hazard.
    cyc("zero_rd");
    clr(); ex_memread = 1'b1; ex_rd = '0; id_rs1 = '0; id_use_rs1 = 1'b1; #1;
    chk_ctl("zero_rd", 1, 1, 0, 0);

    // Load-use, LOAD_LAT=2: two stall cycles; LOAD_LAT=1 instance stalls one.
    cyc("load_use_c1");
    clr(); load_use_r5(); #1;
    chk_ctl("lu_c1", 0, 0, 1, 0);
    chk("lu_c1.pc_write_1", pc_write_1, 0);
    cyc("load_use_c2");
    clr(); #1;
    chk_ctl("lu_c2", 0, 0, 1, 0);
    chk("lu_c2.pc_write_1", pc_write_1, 1);
    cyc("load_use_c3");
    #1;
    chk_ctl("lu_c3", 1, 1, 0, 0);
    chk("lu.stall_count", stall_count, 2);
    chk("lu.stall_count_1", stall_count_1, 1);

    // Load-use and taken branch together: flush wins, no stall.
    cyc("lu_branch");
    clr(); load_use_r5(); ex_branch_taken = 1'b1; #1;
    chk_ctl("lu_br", 1, 1, 1, 1);
    chk("lu_br.pc_write_1", pc_write_1, 1);
    cyc("lu_branch_flush");
    clr(); #1;
    chk_ctl("lu_br_flush", 1, 1, 1, 1);
    cyc("lu_branch_run");
    #1;
    chk_ctl("lu_br_run", 1, 1, 0, 0);
    chk("lu_br.stall_count", stall_count, 2);

    // Branch arriving mid-STALL aborts the stall into FLUSH.
    cyc("abort_c1");
    clr(); load_use_r5(); #1;
    chk_ctl("abort_c1", 0, 0, 1, 0);
    cyc("abort_branch");
    clr(); ex_branch_taken = 1'b1; #1;
    chk_ctl("abort_br", 1, 1, 1, 1);
    cyc("abort_flush");
    clr(); #1;
    chk_ctl("abort_flush", 1, 1, 1, 1);
    cyc("abort_run");
    #1;
    chk_ctl("abort_run", 1, 1, 0, 0);
    chk("abort.stall_count", stall_count, 3);
    chk("abort.stall_count_1", stall_count_1, 2);

    // ALU dependency on both EX and MEM for rs2.
    cyc("raw_ex_mem");
    clr(); ex_regwrite = 1'b1; ex_rd = 5'd3; mem_regwrite = 1'b1; mem_rd = 5'd3;
    id_rs2 = 5'd3; id_use_rs2 = 1'b1; id_rs1 = 5'd3; #1;
`ifdef HAZARD_FORWARD_EN
    chk("raw_ex_mem.fwd_b", fwd_b, 2'b01);
    chk("raw_ex_mem.fwd_a", fwd_a, 2'b00);
    chk_ctl("raw_ex_mem", 1, 1, 0, 0);
`else
    chk_ctl("raw_ex_mem", 0, 0, 1, 0);
`endif
    cyc("raw_ex_mem_after");
    clr(); #1;
    chk_ctl("raw_ex_mem_after", 1, 1, 0, 0);

    // MEM-only dependency on rs1.
    cyc("raw_mem");
    clr(); mem_regwrite = 1'b1; mem_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; #1;
`ifdef HAZARD_FORWARD_EN
    chk("raw_mem.fwd_a", fwd_a, 2'b10);
    chk("raw_mem.fwd_b", fwd_b, 2'b00);
    chk_ctl("raw_mem", 1, 1, 0, 0);
`else
    chk_ctl("raw_mem", 0, 0, 1, 0);
`endif
    cyc("raw_mem_after");
    clr(); #1;
    chk_ctl("raw_mem_after", 1, 1, 0, 0);
`ifdef HAZARD_FORWARD_EN
    chk("raw.stall_count", stall_count, 3);
    chk("raw.stall_count_1", stall_count_1, 2);
`else
    chk("raw.stall_count", stall_count, 5);
    chk("raw.stall_count_1", stall_count_1, 4);
`endif

    // Asynchronous reset in the middle of a STALL.
    cyc("rst_c1");
    clr(); load_use_r5(); #1;
    chk_ctl("rst_c1", 0, 0, 1, 0);
    cyc("rst_stall");
    clr(); #1;
    chk_ctl("rst_stall", 0, 0, 1, 0);
    #1;
    reset = 1'b1;
    #1;
    chk_ctl("rst_async", 1, 1, 0, 0);
    chk("rst_async.stall_count", stall_count, 0);
    chk("rst_async.stall_count_1", stall_count_1, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc("rst_resume");
    #1;
    chk_ctl("rst_resume", 1, 1, 0, 0);
    chk("rst_resume.stall_count", stall_count, 0);

    // Hold a load-use hazard for 20 cycles: 4-bit counter saturates at 15.
    cyc("sat_start");
    clr(); load_use_r5(); #1;
    chk("sat_start.pc_write_1", pc_write_1, 0);
    for (int i = 0; i < 16; i++) @(posedge clock);
    #1;
    $display("[tb] t=%0t step sat_16", $time);
    chk("sat16.stall_count_1", stall_count_1, 15);
    chk("sat16.stall_count", stall_count, 16);
    for (int i = 0; i < 4; i++) @(posedge clock);
    #1;
    $display("[tb] t=%0t step sat_20", $time);
    chk("sat20.stall_count_1", stall_count_1, 15);
    chk("sat20.stall_count", stall_count, 20);
    clr(); #1;
    chk_ctl("sat_release", 1, 1, 0, 0);
    chk("sat_release.pc_write_1", pc_write_1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_control_unit

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
- REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
- REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (range 1..7).
- REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
- REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
- REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-006 SHALL have ports id_rs1, id_rs2  input  REG_AW  source registers of the instruction in ID.
- REQ-007 SHALL have ports id_use_rs1, id_use_rs2  input  1  source actually read.
- REQ-008 SHALL have ports ex_rd  input  REG_AW, ex_memread  input  1, ex_regwrite  input  1  EX-stage destination info.
- REQ-009 SHALL have ports mem_rd  input  REG_AW, mem_regwrite  input  1  MEM-stage destination info.
- REQ-010 SHALL have port ex_branch_taken  input  1  resolved taken branch or jump in EX.
- REQ-011 SHALL have ports pc_write, if_id_write  output  1  PC and IF/ID enables, active-high.
- REQ-012 SHALL have ports id_ex_bubble, if_id_flush  output  1  insert NOP into ID/EX and clear IF/ID.
- REQ-013 SHALL have port stall_count  output  CNT_W  saturating count of stalled cycles.
- REQ-014 SHALL have ports fwd_a, fwd_b  output  2  operand forward select (only with HAZARD_FORWARD_EN).

Function
- REQ-015 SHALL implement states RUN, STALL, FLUSH.
- REQ-016 SHALL drive pc_write, if_id_write, id_ex_bubble and if_id_flush combinationally from state and the current inputs.
- REQ-017 SHALL define a match on a source as id_use_rsN=1, rsN equal to the stage rd, and rd not equal to 0.
- REQ-018 SHALL detect a load-use hazard when ex_memread=1 and either source matches ex_rd.
- REQ-019 SHALL, on a load-use hazard in RUN, drive pc_write=0, if_id_write=0 and id_ex_bubble=1 in that cycle.
- REQ-020 SHALL, on a load-use hazard in RUN with LOAD_LAT>1, enter STALL with an internal counter loaded to LOAD_LAT-1; with LOAD_LAT=1 it SHALL remain in RUN.
- REQ-021 SHALL, in STALL, hold the stall outputs and decrement the counter, returning to RUN in the cycle after the counter reaches 1.
- REQ-022 SHALL, on ex_branch_taken=1, drive pc_write=1, if_id_flush=1 and id_ex_bubble=1 for that cycle, enter FLUSH for one cycle, then return to RUN.
- REQ-023 SHALL give ex_branch_taken priority over a load-use hazard: no stall starts, and a STALL in progress aborts to FLUSH.
- REQ-024 SHALL, in FLUSH, ignore hazards on the squashed ID instruction and hold if_id_flush=1 and id_ex_bubble=1.
- REQ-025 SHALL drive pc_write=1, if_id_write=1 and all other control outputs 0 in RUN with no hazard.
- REQ-026 SHALL increment stall_count on every cycle with pc_write=0 and saturate at all-ones without wrapping.

Reset
- REQ-027 SHALL, while reset=1, force state RUN, internal counter 0, stall_count 0 and fwd_a=fwd_b=0.
- REQ-028 SHALL cancel any in-progress STALL or FLUSH on reset assertion, and SHALL resume in RUN with no residual stall after release.

Configuration
- REQ-029 SHALL compile forwarding in when macro HAZARD_FORWARD_EN is defined: fwd_x=01 for an EX match with ex_regwrite=1 and ex_memread=0, 10 for a MEM match with mem_regwrite=1, and 00 otherwise; EX takes priority over MEM.
- REQ-030 SHALL, without HAZARD_FORWARD_EN, omit fwd_a and fwd_b and stall one cycle (as in REQ-019, in RUN only) for any regwrite match in EX or MEM.

Structure
- REQ-031 SHALL take the state enum and the fwd select codes (00/01/10) from shared package hazard_pkg.
- REQ-032 SHALL place forwarding logic in sub-module forward_select, instantiated only under HAZARD_FORWARD_EN.

Verification
- REQ-033 SHALL cover: LOAD_LAT=2, ex_memread=1, ex_rd=5, id_rs1=5 -> pc_write=0 for exactly 2 cycles, stall_count=2.
- REQ-034 SHALL cover: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, pc_write=1.
- REQ-035 SHALL cover: load-use and ex_branch_taken in the same cycle -> if_id_flush=1, pc_write=1, no stall cycles follow.
- REQ-036 SHALL cover: forwarding enabled, ex_regwrite=1, ex_rd=3, mem_regwrite=1, mem_rd=3, id_rs2=3 -> fwd_b=01; forwarding disabled -> one-cycle stall.
- REQ-037 SHALL cover: reset asserted mid-STALL -> outputs return to RUN defaults asynchronously, stall_count=0.
- REQ-038 SHALL cover: CNT_W=4 with 20 forced stall cycles -> stall_count holds at 15.
